anycore_l15_resp_encoder: RTL and testbench

//  Return path from L1.5 to Anycore: consumes L1.5 transducer responses and drives Anycore mem2ic/mem2dc ports.

---
 rtl/anycore_l15_resp_encoder_pkg.sv | 15 +
 rtl/anycore_l15_resp_encoder_if.sv | 32 +++
 rtl/anycore_l15_word_swap.sv | 14 +
 rtl/anycore_l15_resp_encoder.sv | 128 ++++++++++++
 tb/tb_anycore_l15_resp_encoder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/anycore_l15_resp_encoder_pkg.sv
// rtl/anycore_l15_resp_encoder_pkg.sv - L1.5 return types and Anycore block-address widths
package anycore_l15_resp_encoder_pkg;

  // Block-address widths, as configured for the Anycore core
  localparam int ICACHE_BLOCK_ADDR_BITS = 26;
  localparam int DCACHE_BLOCK_ADDR_BITS = 28;

  // L1.5 transducer return types
  localparam logic [3:0] RT_LOAD_RET  = 4'b0000;
  localparam logic [3:0] RT_IFILL_RET = 4'b0001;
  localparam logic [3:0] RT_EVICT_REQ = 4'b0011;
  localparam logic [3:0] RT_ST_ACK    = 4'b0100;
  localparam logic [3:0] RT_INT_RET   = 4'b0111;

endpackage

// File: rtl/anycore_l15_resp_encoder_if.sv
// rtl/anycore_l15_resp_encoder_if.sv - L1.5 transducer response channel
interface anycore_l15_resp_encoder_if;

  logic        l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic [63:0] l15_transducer_data_2;
  logic [63:0] l15_transducer_data_3;
  logic        transducer_l15_req_ack;

  modport master (
    output l15_transducer_val,
    output l15_transducer_returntype,
    output l15_transducer_data_0,
    output l15_transducer_data_1,
    output l15_transducer_data_2,
    output l15_transducer_data_3,
    input  transducer_l15_req_ack
  );

  modport slave (
    input  l15_transducer_val,
    input  l15_transducer_returntype,
    input  l15_transducer_data_0,
    input  l15_transducer_data_1,
    input  l15_transducer_data_2,
    input  l15_transducer_data_3,
    output transducer_l15_req_ack
  );

endinterface

// File: rtl/anycore_l15_word_swap.sv
// rtl/anycore_l15_word_swap.sv - byte-reverse one 64-bit word (L1.5 big-endian to little-endian)
module anycore_l15_word_swap (
  input  logic [63:0] word,
  output logic [63:0] swapped
);

  always_comb begin
    swapped = '0;
    for (int i = 0; i < 8; i++) begin
      swapped[8*i +: 8] = word[8*(7-i) +: 8];
    end
  end

endmodule

// File: rtl/anycore_l15_resp_encoder.sv
// rtl/anycore_l15_resp_encoder.sv - L1.5 response return path into Anycore mem2ic/mem2dc
module anycore_l15_resp_encoder
  import anycore_l15_resp_encoder_pkg::*;
#(
  parameter int IC_BEATS    = 2,
  parameter int IC_TAG_BITS = ICACHE_BLOCK_ADDR_BITS,
  parameter int DC_TAG_BITS = DCACHE_BLOCK_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IC_TAG_BITS-1:0]    anycore_ic2mem_reqaddr,
  input  logic                      anycore_ic2mem_reqvalid,
  input  logic [DC_TAG_BITS-1:0]    anycore_dc2mem_ldaddr,
  input  logic                      anycore_dc2mem_ldvalid,
  anycore_l15_resp_encoder_if.slave l15,
  output logic                      anycore_mem2ic_valid,
  output logic [IC_TAG_BITS-1:0]    anycore_mem2ic_tag,
  output logic [128*IC_BEATS-1:0]   anycore_mem2ic_data,
  output logic                      anycore_mem2dc_ldvalid,
  output logic [DC_TAG_BITS-1:0]    anycore_mem2dc_ldtag,
  output logic [127:0]              anycore_mem2dc_lddata,
  output logic                      anycore_mem2dc_stcomplete,
  output logic                      resp_err
);

  localparam int CNT_BITS = (IC_BEATS > 1) ? $clog2(IC_BEATS) : 1;

  logic [63:0]             sw_0;
  logic [63:0]             sw_1;
  logic [127:0]            beat_data;
  logic                    ack_q;
  logic                    ic_pend;
  logic                    ld_pend;
  logic [IC_TAG_BITS-1:0]  ic_tag_q;
  logic [DC_TAG_BITS-1:0]  ld_tag_q;
  logic [CNT_BITS-1:0]     cnt;
  logic [128*IC_BEATS-1:0] line_q;
  logic [128*IC_BEATS-1:0] line_next;

  logic consume, is_ifill, is_load, ic_hit, ic_last, ic_done, ld_hit, bad;
  logic unused_upper_data;

  anycore_l15_word_swap u_swap_0 (.word(l15.l15_transducer_data_0), .swapped(sw_0));
  anycore_l15_word_swap u_swap_1 (.word(l15.l15_transducer_data_1), .swapped(sw_1));

  assign beat_data         = {sw_1, sw_0};
  assign unused_upper_data = ^{l15.l15_transducer_data_2, l15.l15_transducer_data_3};

  // The ack register blocks the held-val cycle that coincides with the ack
  assign consume  = l15.l15_transducer_val && !ack_q;
  assign is_ifill = consume && (l15.l15_transducer_returntype == RT_IFILL_RET);
  assign is_load  = consume && (l15.l15_transducer_returntype == RT_LOAD_RET);
  assign ic_hit   = is_ifill && ic_pend;
  assign ic_last  = (cnt == CNT_BITS'(IC_BEATS - 1));
  assign ic_done  = ic_hit && ic_last;
  assign ld_hit   = is_load && ld_pend;

  // A request that lands on the completing cycle replaces the finished one, so it is not an error
  assign bad = (is_ifill && !ic_pend) || (is_load && !ld_pend) ||
               (anycore_ic2mem_reqvalid && ic_pend && !ic_done) ||
               (anycore_dc2mem_ldvalid && ld_pend && !ld_hit);

  assign l15.transducer_l15_req_ack = ack_q;

  always_comb begin
    line_next = line_q;
    if (ic_hit) begin
      line_next[128*int'(cnt) +: 128] = beat_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q                     <= 1'b0;
      ic_pend                   <= 1'b0;
      ld_pend                   <= 1'b0;
      ic_tag_q                  <= '0;
      ld_tag_q                  <= '0;
      cnt                       <= '0;
      line_q                    <= '0;
      anycore_mem2ic_valid      <= 1'b0;
      anycore_mem2ic_tag        <= '0;
      anycore_mem2ic_data       <= '0;
      anycore_mem2dc_ldvalid    <= 1'b0;
      anycore_mem2dc_ldtag      <= '0;
      anycore_mem2dc_lddata     <= '0;
      anycore_mem2dc_stcomplete <= 1'b0;
      resp_err                  <= 1'b0;
    end else begin
      ack_q                     <= consume;
      anycore_mem2ic_valid      <= ic_done;
      anycore_mem2dc_ldvalid    <= ld_hit;
      anycore_mem2dc_stcomplete <= consume && (l15.l15_transducer_returntype == RT_ST_ACK);

      if (ic_hit) begin
        line_q <= line_next;
        cnt    <= ic_last ? '0 : cnt + CNT_BITS'(1);
      end
      if (ic_done) begin
        anycore_mem2ic_data <= line_next;
        anycore_mem2ic_tag  <= ic_tag_q;
      end

      if (anycore_ic2mem_reqvalid) begin
        ic_pend  <= 1'b1;
        ic_tag_q <= anycore_ic2mem_reqaddr;
      end else if (ic_done) begin
        ic_pend <= 1'b0;
      end

      if (ld_hit) begin
        anycore_mem2dc_lddata <= beat_data;
        anycore_mem2dc_ldtag  <= ld_tag_q;
      end
      if (anycore_dc2mem_ldvalid) begin
        ld_pend  <= 1'b1;
        ld_tag_q <= anycore_dc2mem_ldaddr;
      end else if (ld_hit) begin
        ld_pend <= 1'b0;
      end

      if (bad) begin
        resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_anycore_l15_resp_encoder.sv
// tb/tb_anycore_l15_resp_encoder.sv - scoreboard bench for anycore_l15_resp_encoder
module tb_anycore_l15_resp_encoder;
  import anycore_l15_resp_encoder_pkg::*;

  localparam int ICB   = ICACHE_BLOCK_ADDR_BITS;
  localparam int DCB   = DCACHE_BLOCK_ADDR_BITS;
  localparam int BEATS = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [ICB-1:0]        reqaddr;
  logic                  reqvalid;
  logic [DCB-1:0]        ldaddr;
  logic                  ldvalid;
  logic                  ic_valid;
  logic [ICB-1:0]        ic_tag;
  logic [128*BEATS-1:0]  ic_data;
  logic                  ld_valid;
  logic [DCB-1:0]        ld_tag;
  logic [127:0]          ld_data;
  logic                  st_complete;
  logic                  resp_err;

  anycore_l15_resp_encoder_if l15 ();

  anycore_l15_resp_encoder #(.IC_BEATS(BEATS), .IC_TAG_BITS(ICB), .DC_TAG_BITS(DCB)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .anycore_ic2mem_reqaddr    (reqaddr),
    .anycore_ic2mem_reqvalid   (reqvalid),
    .anycore_dc2mem_ldaddr     (ldaddr),
    .anycore_dc2mem_ldvalid    (ldvalid),
    .l15                       (l15),
    .anycore_mem2ic_valid      (ic_valid),
    .anycore_mem2ic_tag        (ic_tag),
    .anycore_mem2ic_data       (ic_data),
    .anycore_mem2dc_ldvalid    (ld_valid),
    .anycore_mem2dc_ldtag      (ld_tag),
    .anycore_mem2dc_lddata     (ld_data),
    .anycore_mem2dc_stcomplete (st_complete),
    .resp_err                  (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ICB-1:0] tag; logic [128*BEATS-1:0] data; } ic_exp_t;
  typedef struct { logic [DCB-1:0] tag; logic [127:0] data; } ld_exp_t;

  ic_exp_t ic_q[$];
  ld_exp_t ld_q[$];
  int      st_pending = 0;
  int      n_checks   = 0;
  int      n_fail     = 0;
  int      acks_seen  = 0;
  int      resp_sent  = 0;

  bit             m_ic_pend, m_ld_pend, m_err;
  logic [ICB-1:0] m_ic_tag;
  logic [DCB-1:0] m_ld_tag;
  logic [127:0]   m_beats[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] swap64(input logic [63:0] w);
    return {<<8{w}};
  endfunction

  ic_exp_t mon_ic;
  ld_exp_t mon_ld;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (l15.transducer_l15_req_ack) acks_seen++;
      if (ic_valid) begin
        check("ic_expected_pending", ic_q.size() > 0, 1);
        if (ic_q.size() > 0) begin
          mon_ic = ic_q.pop_front();
          check("ic_tag", ic_tag, mon_ic.tag);
          check("ic_data", ic_data, mon_ic.data);
        end
      end
      if (ld_valid) begin
        check("ld_expected_pending", ld_q.size() > 0, 1);
        if (ld_q.size() > 0) begin
          mon_ld = ld_q.pop_front();
          check("ld_tag", ld_tag, mon_ld.tag);
          check("ld_data", ld_data, mon_ld.data);
        end
      end
      if (st_complete) begin
        check("st_expected_pending", st_pending > 0, 1);
        if (st_pending > 0) st_pending--;
      end
    end
  end

  task automatic req_ic(input logic [ICB-1:0] tag);
    @(negedge clk);
    reqaddr  = tag;
    reqvalid = 1'b1;
    if (m_ic_pend) m_err = 1'b1;
    m_ic_pend = 1'b1;
    m_ic_tag  = tag;
    @(negedge clk);
    reqvalid = 1'b0;
  endtask

  task automatic req_ld(input logic [DCB-1:0] tag);
    @(negedge clk);
    ldaddr  = tag;
    ldvalid = 1'b1;
    if (m_ld_pend) m_err = 1'b1;
    m_ld_pend = 1'b1;
    m_ld_tag  = tag;
    @(negedge clk);
    ldvalid = 1'b0;
  endtask

  task automatic send(input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1);
    ic_exp_t              ie;
    ld_exp_t              le;
    logic [128*BEATS-1:0] line;
    int                   t;
    @(negedge clk);
    l15.l15_transducer_val        = 1'b1;
    l15.l15_transducer_returntype = rt;
    l15.l15_transducer_data_0     = d0;
    l15.l15_transducer_data_1     = d1;
    l15.l15_transducer_data_2     = {$urandom, $urandom};
    l15.l15_transducer_data_3     = {$urandom, $urandom};
    resp_sent++;
    if (rt == RT_IFILL_RET) begin
      if (m_ic_pend) begin
        m_beats.push_back({swap64(d1), swap64(d0)});
        if (m_beats.size() == BEATS) begin
          line = '0;
          for (int b = 0; b < BEATS; b++) line[128*b +: 128] = m_beats[b];
          ie.tag  = m_ic_tag;
          ie.data = line;
          ic_q.push_back(ie);
          m_beats.delete();
          m_ic_pend = 1'b0;
        end
      end else begin
        m_err = 1'b1;
      end
    end else if (rt == RT_LOAD_RET) begin
      if (m_ld_pend) begin
        le.tag  = m_ld_tag;
        le.data = {swap64(d1), swap64(d0)};
        ld_q.push_back(le);
        m_ld_pend = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (rt == RT_ST_ACK) begin
      st_pending++;
    end
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!l15.transducer_l15_req_ack && t < 20);
    if (t >= 20) check("ack_timeout", 0, 1);
    // L1.5 keeps val up through the ack cycle
    @(posedge clk);
    #1;
    l15.l15_transducer_val = 1'b0;
    repeat (2) @(negedge clk);
    check("resp_err", resp_err, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_ic_pend = 1'b0;
    m_ld_pend = 1'b0;
    m_err     = 1'b0;
    m_beats.delete();
    repeat (2) @(negedge clk);
    check("rst_ic_valid", ic_valid, 0);
    check("rst_ic_tag", ic_tag, 0);
    check("rst_ic_data", ic_data, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_ld_tag", ld_tag, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_st_complete", st_complete, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_ack", l15.transducer_l15_req_ack, 0);
    rst_n = 1'b1;
  endtask

  logic [3:0] rt_other;
  int         ack_before;

  initial begin
    rst_n    = 1'b0;
    reqaddr  = '0;
    reqvalid = 1'b0;
    ldaddr   = '0;
    ldvalid  = 1'b0;
    l15.l15_transducer_val        = 1'b0;
    l15.l15_transducer_returntype = 4'h0;
    l15.l15_transducer_data_0     = '0;
    l15.l15_transducer_data_1     = '0;
    l15.l15_transducer_data_2     = '0;
    l15.l15_transducer_data_3     = '0;
    do_reset();

    req_ic(ICB'(32'h12));
    send(RT_IFILL_RET, 64'h0011223344556677, 64'h8899aabbccddeeff);
    send(RT_IFILL_RET, 64'h0011223344556677, 64'h1122334455667788);
    check("t1_tag", ic_tag, 32'h12);
    check("t1_data_lo", ic_data[63:0], 64'h7766554433221100);

    req_ld(DCB'(32'h5));
    send(RT_LOAD_RET, 64'h0102030405060708, 64'hdeadbeefcafef00d);
    check("t2_tag", ld_tag, 32'h5);
    check("t2_data_lo", ld_data[63:0], 64'h0807060504030201);

    ack_before = acks_seen;
    send(RT_ST_ACK, 64'h0, 64'h0);
    check("t3_one_ack", acks_seen - ack_before, 1);

    send(RT_LOAD_RET, 64'h1111, 64'h2222);
    repeat (5) @(negedge clk);
    check("t4_err_sticky", resp_err, 1);
    do_reset();

    req_ic(ICB'(32'h2a));
    send(RT_IFILL_RET, 64'ha0a1a2a3a4a5a6a7, 64'hb0b1b2b3b4b5b6b7);
    send(RT_EVICT_REQ, 64'hffffffffffffffff, 64'heeeeeeeeeeeeeeee);
    send(RT_IFILL_RET, 64'hc0c1c2c3c4c5c6c7, 64'hd0d1d2d3d4d5d6d7);

    req_ic(ICB'(32'h33));
    send(RT_IFILL_RET, 64'h5555555555555555, 64'h6666666666666666);
    do_reset();
    req_ic(ICB'(32'h44));
    send(RT_IFILL_RET, 64'h0123456789abcdef, 64'hfedcba9876543210);
    send(RT_IFILL_RET, 64'h1357924680aceb00, 64'h0f1e2d3c4b5a6978);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    req_ic(ICB'($urandom));
        2:       req_ld(DCB'($urandom));
        3, 4, 5: send(RT_IFILL_RET, {$urandom, $urandom}, {$urandom, $urandom});
        6:       send(RT_LOAD_RET, {$urandom, $urandom}, {$urandom, $urandom});
        7:       send(RT_ST_ACK, {$urandom, $urandom}, {$urandom, $urandom});
        8: begin
          do rt_other = 4'($urandom_range(0, 15));
          while (rt_other == RT_LOAD_RET || rt_other == RT_IFILL_RET || rt_other == RT_ST_ACK);
          send(rt_other, {$urandom, $urandom}, {$urandom, $urandom});
        end
        default: if ($urandom_range(0, 9) == 0) do_reset();
      endcase
    end

    repeat (5) @(negedge clk);
    check("ack_count", acks_seen, resp_sent);
    check("ic_queue_drained", ic_q.size(), 0);
    check("ld_queue_drained", ld_q.size(), 0);
    check("st_drained", st_pending, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
